diretorio_controlador: RTL and testbench
========================================

# diretorio_controlador

Home-directory controller for the MSI directory protocol. It sits directly downstream of the per-cache state machines: it takes their read/write miss requests and keeps one directory entry (state plus sharer vector) per block. For each request it issues the required invalidate/fetch messages one at a time and returns the granted cache state. It replaces the testbench-driven directory state with a real, stateful home node.

## Interface
- NCACHES, 2, number of caches (requesters); sharer vector width
- ADDR_W, 2, block index width; directory holds 2**ADDR_W entries

- Clock  in  1  single clock, all state on rising edge
- Resetn  in  1  asynchronous, active-low reset
- ReqValid  in  NCACHES  per-cache miss request pending
- ReqWrite  in  NCACHES  per-cache: 1 = write miss, 0 = read miss
- ReqAddr  in  NCACHES*ADDR_W  per-cache block index, cache i at slice i
- ReqReady  out  NCACHES  one-hot, one-cycle accept pulse
- InvValid  out  1  coherence message to a remote cache pending
- InvTarget  out  NCACHES  one-hot destination
- InvAddr  out  ADDR_W  block index of message
- InvFetch  out  1  1 = fetch (owner writes back), 0 = invalidate only
- InvAck  in  1  target completed message
- RespValid  out  1  one-cycle response pulse
- RespTarget  out  NCACHES  one-hot requester
- RespState  out  3  granted cache state (I=0, S=1, M=2)
- RespWriteBack  out  1  data was supplied by an owner writeback
- DirState  out  3  directory state of the entry under service (0 when IDLE)

## Operation
- FSM states: IDLE, LOOKUP, INV, RESP.
- IDLE: round-robin arbitration among ReqValid. The pointer starts at cache 0 after reset and moves to the cache after the granted one. ReqReady pulses for the winner. Address and op are latched, then the FSM goes to LOOKUP.
- LOOKUP: reads the entry and builds the pending target list:
  - Read, I: no messages. New entry is S, sharers={req}.
  - Read, S: no messages. Sharers |= req.
  - Read, M, owner≠req: one fetch to the owner. New entry is S, sharers={owner,req}. RespWriteBack=1.
  - Read or write, M, owner==req: no messages, grant M, entry unchanged.
  - Write, I: no messages. New entry is M, sharers={req}.
  - Write, S: invalidate every sharer ≠ req, in ascending index. New entry is M, sharers={req}. If req is the only sharer, there are no messages.
  - Write, M, owner≠req: one fetch to the owner. New entry is M, sharers={req}. RespWriteBack=1.
  - Granted state: S for reads, M for writes.
  - Goes to INV if the target list is non-empty, else RESP.
- INV: InvValid is held with stable InvTarget/InvAddr/InvFetch until InvAck is sampled high. The next target is presented the following cycle. After the last ack, the FSM goes to RESP.
- RESP: RespValid pulses and the entry is written in the same cycle. Next state is IDLE.
- InvAck while InvValid=0 is ignored. ReqValid from non-granted caches is held off; requesters must hold ReqValid, ReqWrite and ReqAddr stable until their ReqReady.

## Timing
- Reset (async assert) sets:
  - all entries to I with sharers 0
  - FSM to IDLE and the arbiter pointer to 0
  - every output to 0
- Reset mid-transaction abandons the transaction: no response, no entry update.
- Accept at cycle t gives LOOKUP at t+1. With no messages, RespValid is at t+2. With k messages, each acked in the cycle it is presented, RespValid is at t+2+k. Each cycle of ack delay adds one cycle.
- The earliest next accept is the cycle after RESP (t+3 minimum), so there is at most one outstanding transaction.
- An entry update is visible to the LOOKUP of the next transaction, including one to the same block.
- When both caches request in the same cycle, the round-robin winner is served and the loser is served next.

## Structure
- Package diretorio_pkg holds:
  - state codes EST_I=3'd0, EST_S=3'd1, EST_M=3'd2
  - op codes OP_READ=1'b0, OP_WRITE=1'b1
  - the FSM state enum
  - the directory entry struct {state[2:0], sharers[NCACHES-1:0]}
- Sub-module arbitro_rr: parameterised round-robin arbiter (request vector, advance strobe, one-hot grant, pointer reset to 0).

## Test plan
- After reset, cache0 reads block 1 → ReqReady[0] at t, RespValid t+2, RespState=S, DirState=S. Entry 1 then has sharers=01.
- Caches 0 and 1 both read block 1, then cache1 writes block 1 → one invalidate (InvTarget=01, InvFetch=0). Response RespState=M, entry 1 ends as M, sharers=10.
- Cache0 reads block 1 while it is M in cache1 → fetch (InvTarget=10, InvFetch=1). RespWriteBack=1, entry ends as S, sharers=11.
- Both ReqValid asserted in the same cycle immediately after reset → cache0 is granted first and cache1 next. A third simultaneous pair grants cache1 first if the pointer is there.
- InvAck is delayed 3 cycles → InvValid and its fields stay stable, and RespValid is delayed by 3 cycles. A stray InvAck in IDLE has no effect.
- Resetn is asserted during INV → all outputs go to 0 immediately, all entries return to I, and no RespValid occurs.

Source files
------------

// File: rtl/diretorio_pkg.sv
// Shared encodings for the MSI home-directory controller: cache/op codes,
// FSM states, the directory entry layout and a one-hot helper.
package diretorio_pkg;

    localparam int DIR_NCACHES = 2;
    localparam int DIR_ADDR_W  = 2;

    localparam logic [2:0] EST_I = 3'd0;
    localparam logic [2:0] EST_S = 3'd1;
    localparam logic [2:0] EST_M = 3'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_INV,
        ST_RESP
    } dir_fsm_t;

    typedef struct packed {
        logic [2:0]             state;
        logic [DIR_NCACHES-1:0] sharers;
    } dir_entry_t;

    // Isolates the lowest set bit, which gives ascending-index message order.
    function automatic logic [DIR_NCACHES-1:0] lowest_set(input logic [DIR_NCACHES-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/diretorio_controlador_arbitro.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer;
// the pointer moves past the winner when advance_i is strobed.
module arbitro_rr #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] win_idx;
    logic          found;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] c;
            c = IW'((int'(ptr_q) + k) % N);
            if (!found && req_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                win_idx    = c;
            end
        end
        ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/diretorio_controlador.sv
// MSI home node: arbitrates cache misses, sequences invalidate/fetch messages
// one at a time and keeps one directory entry per block.
module diretorio_controlador
    import diretorio_pkg::*;
#(
    parameter int NCACHES = DIR_NCACHES,
    parameter int ADDR_W  = DIR_ADDR_W
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [NCACHES-1:0]        ReqValid,
    input  logic [NCACHES-1:0]        ReqWrite,
    input  logic [NCACHES*ADDR_W-1:0] ReqAddr,
    output logic [NCACHES-1:0]        ReqReady,
    output logic                      InvValid,
    output logic [NCACHES-1:0]        InvTarget,
    output logic [ADDR_W-1:0]         InvAddr,
    output logic                      InvFetch,
    input  logic                      InvAck,
    output logic                      RespValid,
    output logic [NCACHES-1:0]        RespTarget,
    output logic [2:0]                RespState,
    output logic                      RespWriteBack,
    output logic [2:0]                DirState
);

    localparam int NENT = 1 << ADDR_W;

    dir_fsm_t           state_q;
    dir_entry_t         dir_q [NENT];
    dir_entry_t         new_q;
    logic               run_q;
    logic               op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [NCACHES-1:0] req_oh_q;
    logic [NCACHES-1:0] pend_q;
    logic [2:0]         grant_q;
    logic               wb_q;

    logic               inv_valid_q, inv_fetch_q;
    logic [NCACHES-1:0] inv_target_q;
    logic               resp_valid_q, resp_wb_q;
    logic [NCACHES-1:0] resp_target_q;
    logic [2:0]         resp_state_q, dir_state_q;

    logic               accept_en;
    logic [NCACHES-1:0] grant;
    logic [ADDR_W-1:0]  win_addr;
    logic               win_op;
    dir_entry_t         look_e, look_new;
    logic [NCACHES-1:0] look_tgt, inv_rem;
    logic               look_fetch;
    logic [2:0]         look_grant;

    // run_q keeps ReqReady low while reset is held and for the first cycle after.
    assign accept_en = (state_q == ST_IDLE) && run_q;

    arbitro_rr #(.N(NCACHES)) u_arb (
        .clk_i     (Clock),
        .rst_n_i   (Resetn),
        .req_i     (ReqValid),
        .advance_i (accept_en),
        .grant_o   (grant)
    );

    always_comb begin
        win_addr = '0;
        win_op   = OP_READ;
        for (int k = 0; k < NCACHES; k++) begin
            if (grant[k]) begin
                win_addr = ReqAddr[k*ADDR_W +: ADDR_W];
                win_op   = ReqWrite[k];
            end
        end
    end

    always_comb begin
        look_e     = dir_q[addr_q];
        look_new   = look_e;
        look_tgt   = '0;
        look_fetch = 1'b0;
        look_grant = (op_q == OP_WRITE) ? EST_M : EST_S;
        case (look_e.state)
            EST_S: begin
                if (op_q == OP_READ) begin
                    look_new.sharers = look_e.sharers | req_oh_q;
                end else begin
                    look_tgt = look_e.sharers & ~req_oh_q;
                    look_new = dir_entry_t'{state: EST_M, sharers: req_oh_q};
                end
            end
            EST_M: begin
                if (look_e.sharers == req_oh_q) begin
                    look_grant = EST_M;
                end else begin
                    look_tgt   = look_e.sharers;
                    look_fetch = 1'b1;
                    look_new   = (op_q == OP_READ)
                        ? dir_entry_t'{state: EST_S, sharers: look_e.sharers | req_oh_q}
                        : dir_entry_t'{state: EST_M, sharers: req_oh_q};
                end
            end
            default: look_new = dir_entry_t'{state: look_grant, sharers: req_oh_q};
        endcase
    end

    assign inv_rem = pend_q & ~inv_target_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= ST_IDLE;
            // NOTE: the directory array is reset because "all entries I" is architectural state.
            for (int i = 0; i < NENT; i++) dir_q[i] <= '0;
            new_q         <= '0;
            run_q         <= 1'b0;
            op_q          <= OP_READ;
            addr_q        <= '0;
            req_oh_q      <= '0;
            pend_q        <= '0;
            grant_q       <= EST_I;
            wb_q          <= 1'b0;
            inv_valid_q   <= 1'b0;
            inv_fetch_q   <= 1'b0;
            inv_target_q  <= '0;
            resp_valid_q  <= 1'b0;
            resp_wb_q     <= 1'b0;
            resp_target_q <= '0;
            resp_state_q  <= EST_I;
            dir_state_q   <= EST_I;
        end else begin
            run_q         <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_wb_q     <= 1'b0;
            resp_target_q <= '0;
            resp_state_q  <= EST_I;
            case (state_q)
                ST_IDLE: begin
                    if (accept_en && |ReqValid) begin
                        req_oh_q    <= grant;
                        op_q        <= win_op;
                        addr_q      <= win_addr;
                        dir_state_q <= dir_q[win_addr].state;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    new_q       <= look_new;
                    grant_q     <= look_grant;
                    wb_q        <= look_fetch;
                    dir_state_q <= look_new.state;
                    if (|look_tgt) begin
                        pend_q       <= look_tgt;
                        inv_valid_q  <= 1'b1;
                        inv_target_q <= lowest_set(look_tgt);
                        inv_fetch_q  <= look_fetch;
                        state_q      <= ST_INV;
                    end else begin
                        resp_valid_q  <= 1'b1;
                        resp_target_q <= req_oh_q;
                        resp_state_q  <= look_grant;
                        resp_wb_q     <= look_fetch;
                        state_q       <= ST_RESP;
                    end
                end
                ST_INV: begin
                    if (InvAck) begin
                        pend_q <= inv_rem;
                        if (|inv_rem) begin
                            inv_target_q <= lowest_set(inv_rem);
                        end else begin
                            inv_valid_q   <= 1'b0;
                            inv_target_q  <= '0;
                            inv_fetch_q   <= 1'b0;
                            resp_valid_q  <= 1'b1;
                            resp_target_q <= req_oh_q;
                            resp_state_q  <= grant_q;
                            resp_wb_q     <= wb_q;
                            state_q       <= ST_RESP;
                        end
                    end
                end
                default: begin
                    dir_q[addr_q] <= new_q;
                    dir_state_q   <= EST_I;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady      = accept_en ? grant : '0;
    assign InvValid      = inv_valid_q;
    assign InvTarget     = inv_target_q;
    assign InvAddr       = inv_valid_q ? addr_q : '0;
    assign InvFetch      = inv_fetch_q;
    assign RespValid     = resp_valid_q;
    assign RespTarget    = resp_target_q;
    assign RespState     = resp_state_q;
    assign RespWriteBack = resp_wb_q;
    assign DirState      = dir_state_q;

endmodule

// File: tb/tb_diretorio_controlador.sv
// Randomised bench for diretorio_controlador against a rule-level directory model.
module tb_diretorio_controlador;

    localparam int NC = 2;
    localparam int AW = 2;
    localparam int NE = 1 << AW;

    logic            Clock = 1'b0;
    logic            Resetn = 1'b1;
    logic [NC-1:0]   ReqValid = '0;
    logic [NC-1:0]   ReqWrite = '0;
    logic [NC*AW-1:0] ReqAddr = '0;
    logic [NC-1:0]   ReqReady;
    logic            InvValid;
    logic [NC-1:0]   InvTarget;
    logic [AW-1:0]   InvAddr;
    logic            InvFetch;
    logic            InvAck = 1'b0;
    logic            RespValid;
    logic [NC-1:0]   RespTarget;
    logic [2:0]      RespState;
    logic            RespWriteBack;
    logic [2:0]      DirState;

    always #5 Clock = ~Clock;

    diretorio_controlador #(.NCACHES(NC), .ADDR_W(AW)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .ReqValid     (ReqValid),
        .ReqWrite     (ReqWrite),
        .ReqAddr      (ReqAddr),
        .ReqReady     (ReqReady),
        .InvValid     (InvValid),
        .InvTarget    (InvTarget),
        .InvAddr      (InvAddr),
        .InvFetch     (InvFetch),
        .InvAck       (InvAck),
        .RespValid    (RespValid),
        .RespTarget   (RespTarget),
        .RespState    (RespState),
        .RespWriteBack(RespWriteBack),
        .DirState     (DirState)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference directory: state 0=I 1=S 2=M, sharers as an integer bit set.
    int m_state [NE];
    int m_sh    [NE];
    int m_ptr;

    logic          cur_op   [NC];
    logic [AW-1:0] cur_addr [NC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_state[i] = 0;
            m_sh[i]    = 0;
        end
        m_ptr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, ReqReady, 0);
        chk({tag, "_inv"}, {InvValid, InvTarget, InvAddr, InvFetch}, 0);
        chk({tag, "_resp"}, {RespValid, RespTarget, RespState, RespWriteBack}, 0);
        chk({tag, "_dirstate"}, DirState, 0);
    endtask

    task automatic reset_abort();
        Resetn   = 1'b0;
        InvAck   = 1'b0;
        ReqValid = '0;
        #1;
        chk_all_zero("abort_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock); #1;
            chk("abort_no_resp", RespValid, 0);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        model_reset();
    endtask

    // Presents requests from the caches in vmask and serves them all, checking
    // every cycle of each transaction against the model. ack_dly<0 => random.
    task automatic serve_round(input logic [NC-1:0] vmask, input int ack_dly, input bit abort);
        logic [NC-1:0] pend;
        int budget, w, a, st, sh, req, g, nst, nsh, d;
        bit wr, fetch;
        int q_tgt[$];
        @(negedge Clock);
        for (int i = 0; i < NC; i++) begin
            ReqWrite[i]           = cur_op[i];
            ReqAddr[i*AW +: AW]   = cur_addr[i];
        end
        ReqValid = vmask;
        pend     = vmask;
        #1;
        while (pend != 0) begin
            budget = 0;
            while (ReqReady == 0 && budget < 20) begin
                @(negedge Clock); #1;
                budget++;
            end
            if (ReqReady == 0) begin
                chk("accept_timeout", 0, 1);
                ReqValid = '0;
                return;
            end
            w = -1;
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m_ptr + k) % NC;
                if (w < 0 && pend[c]) w = c;
            end
            chk("req_ready", ReqReady, 1 << w);
            m_ptr = (w + 1) % NC;

            a   = cur_addr[w];
            wr  = cur_op[w];
            req = 1 << w;
            st  = m_state[a];
            sh  = m_sh[a];
            q_tgt.delete();
            fetch = 0;
            if (st == 2 && sh == req) begin
                g = 2; nst = 2; nsh = sh;
            end else if (st == 2) begin
                q_tgt.push_back(sh);
                fetch = 1;
                g     = wr ? 2 : 1;
                nst   = g;
                nsh   = wr ? req : (sh | req);
            end else if (wr) begin
                for (int i = 0; i < NC; i++)
                    if (st == 1 && sh[i] && i != w) q_tgt.push_back(1 << i);
                g = 2; nst = 2; nsh = req;
            end else begin
                g = 1; nst = 1; nsh = sh | req;
            end

            @(negedge Clock);
            ReqValid[w] = 1'b0;
            pend[w]     = 1'b0;
            #1;
            chk("lookup_ready", ReqReady, 0);
            chk("lookup_quiet", {InvValid, RespValid}, 0);

            foreach (q_tgt[m]) begin
                d = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
                for (int j = 0; j <= d; j++) begin
                    @(negedge Clock); #1;
                    chk("inv_valid", InvValid, 1);
                    chk("inv_target", InvTarget, q_tgt[m]);
                    chk("inv_addr", InvAddr, a);
                    chk("inv_fetch", InvFetch, fetch);
                    chk("inv_no_resp", RespValid, 0);
                    if (abort) begin
                        reset_abort();
                        return;
                    end
                    InvAck = (j == d);
                end
            end

            @(negedge Clock);
            InvAck = 1'b0;
            #1;
            chk("resp_valid", RespValid, 1);
            chk("resp_target", RespTarget, req);
            chk("resp_state", RespState, g);
            chk("resp_wb", RespWriteBack, fetch);
            chk("resp_dirstate", DirState, nst);
            chk("resp_inv_idle", InvValid, 0);
            m_state[a] = nst;
            m_sh[a]    = nsh;

            @(negedge Clock); #1;
            chk("resp_pulse", RespValid, 0);
            chk("idle_dirstate", DirState, 0);
        end
    endtask

    task automatic set_req(input int c, input logic op, input int addr);
        cur_op[c]   = op;
        cur_addr[c] = addr[AW-1:0];
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NC; i++) set_req(i, 1'b0, 0);
        #2 Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        #1;
        chk_all_zero("reset");
        @(negedge Clock);
        Resetn = 1'b1;

        // Simultaneous reads of block 1 right after reset: cache0 then cache1.
        set_req(0, 1'b0, 1);
        set_req(1, 1'b0, 1);
        serve_round(2'b11, 0, 1'b0);
        // Cache1 write: one invalidate to cache0, ack held off 3 cycles.
        set_req(1, 1'b1, 1);
        serve_round(2'b10, 3, 1'b0);
        // Cache0 read while cache1 owns: fetch with writeback.
        set_req(0, 1'b0, 1);
        serve_round(2'b01, 0, 1'b0);

        // Stray acks while idle must not disturb anything.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            InvAck = 1'b1;
            #1;
            chk("stray_ack_quiet", {InvValid, RespValid}, 0);
        end
        @(negedge Clock);
        InvAck = 1'b0;

        // Pointer now sits at cache1, so a fresh pair starts with cache1.
        set_req(0, 1'b1, 1);
        set_req(1, 1'b0, 0);
        serve_round(2'b11, 1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < NC; c++)
                set_req(c, logic'($urandom_range(0, 1)), $urandom_range(0, NE - 1));
            serve_round(NC'($urandom_range(1, 3)), -1, 1'b0);
        end

        // Build S{0,1} on block 2, then reset while the write's invalidate is out.
        set_req(0, 1'b0, 2);
        set_req(1, 1'b0, 2);
        serve_round(2'b11, 0, 1'b0);
        set_req(1, 1'b1, 2);
        serve_round(2'b10, 0, 1'b1);
        // Block 2 must be I again: cache0 write needs no invalidate; pointer back at 0.
        set_req(0, 1'b1, 2);
        set_req(1, 1'b0, 3);
        serve_round(2'b11, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
